dsram_port_arbiter: RTL and testbench

//  Shares the single data-SRAM port between two requesters. Port 0 is the EXE-stage load/store

---
 rtl/dsram_arb_pkg.sv | 18 +
 rtl/dsram_arb_pick.sv | 72 +++++++
 rtl/dsram_port_arbiter.sv | 113 +++++++++++
 tb/tb_dsram_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_arb_pkg.sv
// Shared types for the data-SRAM port arbiter: FSM encoding, owner IDs and the in-flight read tag.
`timescale 1ns/1ps
package dsram_arb_pkg;

   typedef enum logic {
      ARB_NORMAL = 1'b0,
      ARB_FORCE  = 1'b1
   } arb_state_e;

   localparam logic OWNER_P0 = 1'b0;
   localparam logic OWNER_P1 = 1'b1;

   typedef struct packed {
      logic vld;
      logic owner;
   } tag_t;

endpackage

// File: rtl/dsram_arb_pick.sv
// Grant selection for the two SRAM requesters: fixed priority to port 0 with a starvation
// counter that forces a grant to port 1.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ARB_NORMAL | port 0 has priority; starve_q counts port 1 denials
//   ARB_FORCE  | port 1 has priority until it is granted or withdraws
`timescale 1ns/1ps
module dsram_arb_pick
   import dsram_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic p0_req_i,
   input  logic p1_req_i,
   output logic p0_gnt_o,
   output logic p1_gnt_o
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   arb_state_e state_q, state_d;
   logic [3:0] starve_q, starve_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ARB_NORMAL;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // The switch to FORCE uses the incremented count so port 1 wins on the very next cycle.
   always_comb begin
      starve_d = starve_q;
      state_d  = state_q;
      if (!p1_req_i || p1_gnt_o) begin
         starve_d = '0;
      end else begin
         starve_d = starve_q + 4'd1;
      end
      case (state_q)
         ARB_NORMAL: if (starve_d >= STARVE_LIM) state_d = ARB_FORCE;
         ARB_FORCE:  if (p1_gnt_o || !p1_req_i) state_d = ARB_NORMAL;
         default:    state_d = ARB_NORMAL;
      endcase
   end

   always_comb begin
      p0_gnt_o = 1'b0;
      p1_gnt_o = 1'b0;
      case (state_q)
         ARB_NORMAL: begin
            p0_gnt_o = p0_req_i;
            p1_gnt_o = p1_req_i & ~p0_req_i;
         end
         ARB_FORCE: begin
            p1_gnt_o = p1_req_i;
            p0_gnt_o = p0_req_i & ~p1_req_i;
         end
         default: begin
            p0_gnt_o = 1'b0;
            p1_gnt_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dsram_port_arbiter.sv
// Shares one data-SRAM port between the EXE load/store path (port 0) and an auxiliary master
// (port 1). Optional counters are enabled with `define DSRAM_ARB_PERF_EN.
`timescale 1ns/1ps
module dsram_port_arbiter
   import dsram_arb_pkg::*;
#(
   parameter int SRAM_LAT   = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        p0_req_i,
   input  logic [3:0]  p0_we_i,
   input  logic [31:0] p0_addr_i,
   input  logic [31:0] p0_wdata_i,
   output logic        p0_gnt_o,
   output logic        p0_rvalid_o,
   input  logic        p1_req_i,
   input  logic [3:0]  p1_we_i,
   input  logic [31:0] p1_addr_i,
   input  logic [31:0] p1_wdata_i,
   output logic        p1_gnt_o,
   output logic        p1_rvalid_o,
   output logic [31:0] rdata_o,
   output logic        sram_en_o,
   output logic [3:0]  sram_we_o,
   output logic [31:0] sram_addr_o,
   output logic [31:0] sram_wdata_o,
   input  logic [31:0] sram_rdata_i
`ifdef DSRAM_ARB_PERF_EN
   ,
   input  logic        perf_clr_i,
   output logic [31:0] perf_p0_gnt_o,
   output logic [31:0] perf_p1_gnt_o,
   output logic [31:0] perf_conflict_o
`endif
);

   logic p0_gnt, p1_gnt;
   tag_t tag_d;
   tag_t tag_q [SRAM_LAT];

   dsram_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .p0_req_i (p0_req_i),
      .p1_req_i (p1_req_i),
      .p0_gnt_o (p0_gnt),
      .p1_gnt_o (p1_gnt)
   );

   always_comb begin
      sram_en_o    = p0_gnt | p1_gnt;
      sram_we_o    = '0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      if (p1_gnt) begin
         sram_we_o    = p1_we_i;
         sram_addr_o  = p1_addr_i;
         sram_wdata_o = p1_wdata_i;
      end else if (p0_gnt) begin
         sram_we_o    = p0_we_i;
         sram_addr_o  = p0_addr_i;
         sram_wdata_o = p0_wdata_i;
      end
   end

   always_comb begin
      tag_d.vld   = (p0_gnt & (p0_we_i == 4'h0)) | (p1_gnt & (p1_we_i == 4'h0));
      tag_d.owner = p1_gnt ? OWNER_P1 : OWNER_P0;
   end

   // One stage per SRAM cycle, so the last stage lines up with sram_rdata_i.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < SRAM_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_d;
         for (int i = 1; i < SRAM_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign p0_gnt_o    = p0_gnt;
   assign p1_gnt_o    = p1_gnt;
   assign p0_rvalid_o = tag_q[SRAM_LAT-1].vld & (tag_q[SRAM_LAT-1].owner == OWNER_P0);
   assign p1_rvalid_o = tag_q[SRAM_LAT-1].vld & (tag_q[SRAM_LAT-1].owner == OWNER_P1);
   assign rdata_o     = sram_rdata_i;

`ifdef DSRAM_ARB_PERF_EN
   logic [31:0] perf_p0_q, perf_p1_q, perf_cf_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         perf_p0_q <= '0;
         perf_p1_q <= '0;
         perf_cf_q <= '0;
      end else if (perf_clr_i) begin
         perf_p0_q <= '0;
         perf_p1_q <= '0;
         perf_cf_q <= '0;
      end else begin
         perf_p0_q <= perf_p0_q + {31'd0, p0_gnt};
         perf_p1_q <= perf_p1_q + {31'd0, p1_gnt};
         perf_cf_q <= perf_cf_q + {31'd0, p0_req_i & p1_req_i};
      end
   end

   assign perf_p0_gnt_o   = perf_p0_q;
   assign perf_p1_gnt_o   = perf_p1_q;
   assign perf_conflict_o = perf_cf_q;
`endif

endmodule

// File: tb/tb_dsram_port_arbiter.sv
// Scoreboard bench for dsram_port_arbiter: two instances (SRAM_LAT 1 and 3) share one stimulus
// stream; each has its own SRAM model, expected-read queue and response monitor.
`timescale 1ns/1ps
module tb_dsram_port_arbiter;
   import dsram_arb_pkg::*;

   typedef struct packed {
      logic        owner;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        p0_req = 1'b0, p1_req = 1'b0;
   logic [3:0]  p0_we = '0, p1_we = '0;
   logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
   logic        perf_clr = 1'b0;

   logic [1:0]  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, sram_en;
   logic [31:0] rdata [2];
   logic [3:0]  sram_we [2];
   logic [31:0] sram_addr [2], sram_wdata [2], sram_rdata [2];
   logic [31:0] perf_p0 [2], perf_p1 [2], perf_cf [2];

   int   n_tests = 0, n_fail = 0, cyc = 0;
   exp_t exp_q [2][$];
   logic [31:0] exp_mem [logic [29:0]];

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input logic [29:0] w);
      return {w[15:0] ^ 16'hA5C3, w[15:0]};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gen
      localparam int L = (g == 0) ? 1 : 3;
      logic [31:0] mem [logic [29:0]];
      logic [31:0] rpipe [L];

      dsram_port_arbiter #(.SRAM_LAT(L), .STARVE_MAX(4)) u_dut (
         .clk_i        (clk_i),
         .rst_n_i      (rst_n_i),
         .p0_req_i     (p0_req),
         .p0_we_i      (p0_we),
         .p0_addr_i    (p0_addr),
         .p0_wdata_i   (p0_wdata),
         .p0_gnt_o     (p0_gnt[g]),
         .p0_rvalid_o  (p0_rvalid[g]),
         .p1_req_i     (p1_req),
         .p1_we_i      (p1_we),
         .p1_addr_i    (p1_addr),
         .p1_wdata_i   (p1_wdata),
         .p1_gnt_o     (p1_gnt[g]),
         .p1_rvalid_o  (p1_rvalid[g]),
         .rdata_o      (rdata[g]),
         .sram_en_o    (sram_en[g]),
         .sram_we_o    (sram_we[g]),
         .sram_addr_o  (sram_addr[g]),
         .sram_wdata_o (sram_wdata[g]),
         .sram_rdata_i (sram_rdata[g])
`ifdef DSRAM_ARB_PERF_EN
         ,
         .perf_clr_i      (perf_clr),
         .perf_p0_gnt_o   (perf_p0[g]),
         .perf_p1_gnt_o   (perf_p1[g]),
         .perf_conflict_o (perf_cf[g])
`endif
      );

      always @(posedge clk_i) begin : sram_model
         logic [31:0] w;
         w = mem.exists(sram_addr[g][31:2]) ? mem[sram_addr[g][31:2]] : pat(sram_addr[g][31:2]);
         for (int i = L - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
         rpipe[0] <= (sram_en[g] && sram_we[g] == 4'h0) ? w : 32'h0BAD_0BAD;
         if (sram_en[g] && sram_we[g] != 4'h0) begin
            for (int b = 0; b < 4; b++) if (sram_we[g][b]) w[8*b +: 8] = sram_wdata[g][8*b +: 8];
            mem[sram_addr[g][31:2]] = w;
         end
      end
      assign sram_rdata[g] = rpipe[L-1];

      always @(negedge clk_i) begin : monitor
         exp_t e;
         if (rst_n_i && (p0_rvalid[g] || p1_rvalid[g])) begin
            n_tests++;
            if (p0_rvalid[g] && p1_rvalid[g]) begin
               n_fail++;
               $display("FAIL rvalid_onehot inst%0d cyc %0d: both rvalid high, required at most one", g, cyc);
            end else if (exp_q[g].size() == 0) begin
               n_fail++;
               $display("FAIL rvalid_unexpected inst%0d cyc %0d: got rvalid owner %0d, required none", g, cyc, p1_rvalid[g]);
            end else begin
               e = exp_q[g].pop_front();
               if (p1_rvalid[g] !== e.owner || rdata[g] !== e.data || cyc != e.due) begin
                  n_fail++;
                  $display("FAIL rvalid inst%0d: got owner %0d data %h cyc %0d, required owner %0d data %h cyc %0d",
                           g, p1_rvalid[g], rdata[g], cyc, e.owner, e.data, e.due);
               end
            end
         end
      end
   end

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      return exp_mem.exists(a[31:2]) ? exp_mem[a[31:2]] : pat(a[31:2]);
   endfunction

   task automatic note_access(input logic own, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] w;
      exp_t e;
      w = exp_rd(a);
      if (we == 4'h0) begin
         e = '{owner: own, data: w, due: cyc + 1};
         exp_q[0].push_back(e);
         e.due = cyc + 3;
         exp_q[1].push_back(e);
      end else begin
         for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = d[8*b +: 8];
         exp_mem[a[31:2]] = w;
      end
   endtask

   // One cycle with the currently driven requests; e0/e1 are the hand-derived grants.
   task automatic cyc_chk(input logic e0, input logic e1, input string nm);
      logic [72:0] exp_v, act_v;
      if (e0) note_access(OWNER_P0, p0_we, p0_addr, p0_wdata);
      if (e1) note_access(OWNER_P1, p1_we, p1_addr, p1_wdata);
      if (e1)      exp_v = {e0, e1, 1'b1, p1_we, p1_addr, p1_wdata};
      else if (e0) exp_v = {e0, e1, 1'b1, p0_we, p0_addr, p0_wdata};
      else         exp_v = {e0, e1, 1'b0, 4'h0, 32'h0, 32'h0};
      @(negedge clk_i);
      for (int g = 0; g < 2; g++) begin
         act_v = {p0_gnt[g], p1_gnt[g], sram_en[g], sram_we[g], sram_addr[g], sram_wdata[g]};
         n_tests++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got gnt/en/we/addr/wdata %h, required %h", nm, g, cyc, act_v, exp_v);
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_p0(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d;
   endtask

   task automatic set_p1(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d;
   endtask

   task automatic idle(input int n);
      p0_req = 1'b0;
      p1_req = 1'b0;
      repeat (n) cyc_chk(1'b0, 1'b0, "idle");
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc %0d: got %h, required %h", nm, cyc, act, req);
      end
   endtask

   initial begin
      logic [9:0] t2_p1;
      t2_p1 = 10'b10_0001_0000;

      // reset: outputs quiet, grants still follow the requests
      set_p0(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      set_p1(1'b1, 4'h0, 32'h0000_0044, 32'h0);
      @(negedge clk_i);
      for (int g = 0; g < 2; g++)
         chk32($sformatf("reset_outputs inst%0d", g),
               {28'h0, p0_gnt[g], p1_gnt[g], p0_rvalid[g], p1_rvalid[g]}, 32'h8);
      @(posedge clk_i); #1;
      set_p0(1'b0, 4'h0, 32'h0, 32'h0);
      set_p1(1'b0, 4'h0, 32'h0, 32'h0);
      rst_n_i = 1'b1;
      idle(2);

      // T1: lone p0 read
      set_p0(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      cyc_chk(1'b1, 1'b0, "t1_p0_read");
      idle(4);

      // T2: sustained conflict, starvation forces every fifth grant to p1
      set_p0(1'b1, 4'hF, 32'h0000_0800, 32'h1111_0000);
      set_p1(1'b1, 4'hF, 32'h0000_0900, 32'h2222_0000);
      for (int i = 0; i < 10; i++) cyc_chk(~t2_p1[i], t2_p1[i], $sformatf("t2_conflict_%0d", i));
      // p1 withdraws while FORCE is pending, then p0 must win again
      for (int i = 0; i < 4; i++) cyc_chk(1'b1, 1'b0, "t2_build");
      p1_req = 1'b0;
      cyc_chk(1'b1, 1'b0, "t2_withdraw");
      p1_req = 1'b1;
      cyc_chk(1'b1, 1'b0, "t2_after_withdraw");
      idle(1);

      // T3: writes then reads, including a byte-masked write
      set_p1(1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF);
      cyc_chk(1'b0, 1'b1, "t3_p1_write");
      p1_req = 1'b0;
      set_p0(1'b1, 4'h0, 32'h0000_0200, 32'h0);
      cyc_chk(1'b1, 1'b0, "t3_p0_read");
      set_p0(1'b1, 4'b0011, 32'h0000_0300, 32'h1234_5678);
      cyc_chk(1'b1, 1'b0, "t3_p0_partial_write");
      p0_req = 1'b0;
      set_p1(1'b1, 4'h0, 32'h0000_0300, 32'h0);
      cyc_chk(1'b0, 1'b1, "t3_p1_read");
      idle(4);

      // T4: alternating single-cycle reads from both ports
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            p1_req = 1'b0;
            set_p0(1'b1, 4'h0, 32'h0000_0400 + 32'(4 * i), 32'h0);
            cyc_chk(1'b1, 1'b0, "t4_alt_p0");
         end else begin
            p0_req = 1'b0;
            set_p1(1'b1, 4'h0, 32'h0000_0400 + 32'(4 * i), 32'h0);
            cyc_chk(1'b0, 1'b1, "t4_alt_p1");
         end
      end
      idle(4);

      // T5: reset with reads in flight and the FSM in FORCE
      set_p0(1'b1, 4'h0, 32'h0000_0500, 32'h0);
      set_p1(1'b1, 4'hF, 32'h0000_0A00, 32'h3333_3333);
      for (int i = 0; i < 4; i++) begin
         p0_addr = 32'h0000_0500 + 32'(4 * i);
         cyc_chk(1'b1, 1'b0, "t5_reads");
      end
      chk32("t5_state_before_reset", {31'h0, gen[0].u_dut.u_pick.state_q}, {31'h0, ARB_FORCE});
      rst_n_i = 1'b0;
      exp_q[0].delete();
      exp_q[1].delete();
      set_p0(1'b0, 4'h0, 32'h0, 32'h0);
      set_p1(1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      chk32("t5_state0", {31'h0, gen[0].u_dut.u_pick.state_q}, {31'h0, ARB_NORMAL});
      chk32("t5_state1", {31'h0, gen[1].u_dut.u_pick.state_q}, {31'h0, ARB_NORMAL});
      chk32("t5_starve0", {28'h0, gen[0].u_dut.u_pick.starve_q}, 32'h0);
      chk32("t5_starve1", {28'h0, gen[1].u_dut.u_pick.starve_q}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk32("t5_no_rvalid", {28'h0, p0_rvalid, p1_rvalid}, 32'h0);
         @(posedge clk_i); #1;
      end

      // T6: seven conflict cycles from a fresh NORMAL state, then a counter clear
`ifdef DSRAM_ARB_PERF_EN
      for (int g = 0; g < 2; g++) chk32($sformatf("t6_perf_reset inst%0d", g), perf_cf[g], 32'h0);
`endif
      set_p0(1'b1, 4'hF, 32'h0000_0C00, 32'h4444_0000);
      set_p1(1'b1, 4'hF, 32'h0000_0D00, 32'h5555_0000);
      for (int i = 0; i < 7; i++) cyc_chk(i != 4, i == 4, $sformatf("t6_conflict_%0d", i));
      idle(1);
`ifdef DSRAM_ARB_PERF_EN
      for (int g = 0; g < 2; g++) begin
         chk32($sformatf("t6_perf_conflict inst%0d", g), perf_cf[g], 32'd7);
         chk32($sformatf("t6_perf_p0 inst%0d", g), perf_p0[g], 32'd6);
         chk32($sformatf("t6_perf_p1 inst%0d", g), perf_p1[g], 32'd1);
      end
      perf_clr = 1'b1;
      @(posedge clk_i); #1;
      perf_clr = 1'b0;
      for (int g = 0; g < 2; g++) begin
         chk32($sformatf("t6_perf_clr_conflict inst%0d", g), perf_cf[g], 32'h0);
         chk32($sformatf("t6_perf_clr_p0 inst%0d", g), perf_p0[g], 32'h0);
      end
`endif

      idle(5);
      for (int g = 0; g < 2; g++)
         chk32($sformatf("pending_reads inst%0d", g), 32'(exp_q[g].size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion before 200000ns");
      $fatal(1, "timeout");
   end

endmodule
